mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified word-addressed memory between two requesters: the instruction fetch unit and the load/store unit.
- Sits between the CPU datapath and the memory block, and drives that block's address, write data, write enable and read enable.
- Arbitration is data-priority with a starvation cap for fetch.
- Supports exception flush (jisr), which kills an in-flight fetch response.

Parameters:
- ADDR_W, 30, word-address width.
- DATA_W, 32, data width.
- MAX_D_RUN, 4, max consecutive data grants while if_req is pending before fetch is forced a grant (range 1..15).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- jisr  input  1  exception flush; kills fetch in flight, blocks fetch grant this cycle
- if_req  input  1  fetch read request, held until if_gnt
- if_addr  input  ADDR_W  fetch word address
- if_gnt  output  1  fetch request accepted this cycle (combinational)
- if_rvalid  output  1  fetch read data valid (registered)
- if_rdata  output  DATA_W  fetch read data
- d_req  input  1  data request, held until d_gnt
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_W  data word address
- d_wdata  input  DATA_W  store data
- d_gnt  output  1  data request accepted this cycle (combinational)
- d_rvalid  output  1  load data valid (registered; never for stores)
- d_rdata  output  DATA_W  load data
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_wren  output  1  memory write enable
- mem_rren  output  1  memory read enable
- mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_rren

Behaviour:
- Reset: state IDLE, run counter 0, if_rvalid/d_rvalid 0, all gnt and mem_* enables 0, mem_addr/mem_wdata 0.
- Reset mid-operation: any outstanding response is discarded; no rvalid follows reset.
- Memory has 1-cycle read latency, so at most one read is outstanding. Issue is allowed every cycle, including the cycle a response returns, giving full back-to-back throughput.
- Outstanding-owner FSM (registered):
  - IDLE: nothing outstanding.
  - RESP_IF: fetch read issued last cycle.
  - RESP_D: load issued last cycle.
  - RESP_KILL: fetch read issued last cycle, then flushed.
  - The next state is set by the current-cycle grant: fetch grant -> RESP_IF; load grant -> RESP_D; store grant or no grant -> IDLE.
  - Overrides: RESP_IF with jisr=1 goes to RESP_KILL for the response cycle. A fetch issued in the same cycle as jisr is impossible, because jisr blocks the fetch grant.
- Responses, in any state:
  - RESP_IF and jisr=0: if_rvalid=1, if_rdata=mem_rdata.
  - RESP_IF and jisr=1 in the response cycle: the response is suppressed (if_rvalid=0).
  - RESP_D: d_rvalid=1, d_rdata=mem_rdata. Never suppressed by jisr.
  - RESP_KILL: both rvalid 0.
  - rdata outputs are pass-through of mem_rdata and hold no meaning when the matching rvalid is 0.
- Grant rules, evaluated each cycle:
  - fetch_ok = if_req & ~jisr.
  - d_req & ~fetch_ok -> grant data.
  - fetch_ok & ~d_req -> grant fetch.
  - Both: grant fetch if run_cnt == MAX_D_RUN, else grant data.
  - At most one grant per cycle.
- run_cnt (4-bit):
  - +1 on a data grant while if_req=1, saturating at MAX_D_RUN.
  - Cleared on a fetch grant, or on any cycle with if_req=0.
- Memory drive on grant (combinational, same cycle):
  - mem_addr = granted address.
  - Store: mem_wren=1, mem_rren=0, mem_wdata=d_wdata. A store completes at grant; no response.
  - Load/fetch: mem_rren=1, mem_wren=0.
  - No grant: both enables 0; mem_addr and mem_wdata hold 0.
- Requesters must keep req/addr/data stable until granted. A drop before grant is legal and simply withdraws the request.

Test Plan:
- Reset, then fetch only: if_req=1, if_addr=0x10 -> if_gnt=1, mem_rren=1, mem_addr=0x10 at T. At T+1, if_rvalid=1 and if_rdata=mem_rdata (e.g. 0x240B0007). Back-to-back fetches 0x10,0x11,0x12 give three consecutive rvalids.
- Store then load same address: d_we=1, addr 0x5, data 0xDEADBEEF -> mem_wren=1, no d_rvalid. Next cycle load 0x5 -> d_rvalid=1 one cycle later with 0xDEADBEEF.
- Contention, MAX_D_RUN=4, if_req and d_req held high 8 cycles -> grant pattern D,D,D,D,IF,D,D,D; run_cnt resets after the IF grant.
- Flush: fetch granted at T, jisr=1 at T+1 -> if_rvalid=0 at T+1, and no if_gnt at T+1 even with if_req=1. A load granted at T+1 still returns d_rvalid at T+2.
- rst asserted in the cycle after a load grant -> d_rvalid=0; all outputs 0 the next cycle; normal operation resumes after rst deasserts.
- Idle with no requests: mem_wren=mem_rren=0 and both rvalids 0 for 10 cycles; drop if_req before grant under contention -> no fetch grant or response.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port word memory between instruction fetch and load/store.
// Data has priority; fetch is forced through after MAX_D_RUN consecutive data wins.
module mem_port_arbiter #(
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32,
    parameter int MAX_D_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jisr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic              mem_rren,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D    = 2'd2,
        RESP_KILL = 2'd3
    } state_t;

    localparam logic [3:0] RUN_MAX = 4'(MAX_D_RUN);

    state_t     state_r;
    state_t     state_nx_s;
    logic [3:0] run_cnt_r;
    logic [3:0] run_cnt_nx_s;
    logic       fetch_ok_s;
    logic       grant_if_s;
    logic       grant_d_s;

    // Grant selection: data first, fetch forced once the data run hits its cap.
    always_comb begin
        fetch_ok_s = if_req & ~jisr;
        grant_if_s = 1'b0;
        grant_d_s  = 1'b0;
        if (rst) begin
            grant_if_s = 1'b0;
            grant_d_s  = 1'b0;
        end else if (fetch_ok_s && d_req) begin
            if (run_cnt_r == RUN_MAX) begin
                grant_if_s = 1'b1;
            end else begin
                grant_d_s = 1'b1;
            end
        end else if (fetch_ok_s) begin
            grant_if_s = 1'b1;
        end else if (d_req) begin
            grant_d_s = 1'b1;
        end else begin
            grant_if_s = 1'b0;
            grant_d_s  = 1'b0;
        end
        if_gnt = grant_if_s;
        d_gnt  = grant_d_s;
    end

    // Memory port drive for the granted request; address and data park at zero when idle.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        mem_rren  = 1'b0;
        if (grant_if_s) begin
            mem_addr = if_addr;
            mem_rren = 1'b1;
        end else if (grant_d_s) begin
            mem_addr = d_addr;
            if (d_we) begin
                mem_wren  = 1'b1;
                mem_wdata = d_wdata;
            end else begin
                mem_rren = 1'b1;
            end
        end else begin
            mem_addr = '0;
        end
    end

    // Response routing from the outstanding-owner state; a flush in the response cycle drops fetch data.
    always_comb begin
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = mem_rdata;
        d_rdata   = mem_rdata;
        case (state_r)
            RESP_IF:   if_rvalid = ~rst & ~jisr;
            RESP_D:    d_rvalid  = ~rst;
            RESP_KILL: if_rvalid = 1'b0;
            IDLE:      d_rvalid  = 1'b0;
            default:   d_rvalid  = 1'b0;
        endcase
    end

    // Next owner and data-run counter; a flushed fetch parks in RESP_KILL only when nothing new issues.
    always_comb begin
        state_nx_s   = IDLE;
        run_cnt_nx_s = run_cnt_r;
        if (grant_if_s) begin
            state_nx_s = RESP_IF;
        end else if (grant_d_s && !d_we) begin
            state_nx_s = RESP_D;
        end else if ((state_r == RESP_IF) && jisr && !grant_d_s) begin
            state_nx_s = RESP_KILL;
        end else begin
            state_nx_s = IDLE;
        end

        if (!if_req || grant_if_s) begin
            run_cnt_nx_s = 4'd0;
        end else if (grant_d_s) begin
            run_cnt_nx_s = (run_cnt_r == RUN_MAX) ? run_cnt_r : run_cnt_r + 4'd1;
        end else begin
            run_cnt_nx_s = run_cnt_r;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            run_cnt_r <= 4'd0;
        end else begin
            state_r   <= state_nx_s;
            run_cnt_r <= run_cnt_nx_s;
        end
    end

endmodule
